pc_stall_timer: RTL and testbench

//   Multi-channel, clock-synchronous PC stall generator. Each of NUM_CH request lines, on a rising

---
 rtl/pc_stall_timer.sv | 116 +++++++++++
 tb/tb_pc_stall_timer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stall_timer.sv
// pc_stall_timer: multi-channel program-counter stall generator.
// Each delayEn line, on a rising edge, holds pcEn low for its programmed
// number of clk cycles. busy shows which channels are counting, and done
// gives a one-cycle pulse when a channel's stall completes.
// Optional feature macro: STALL_ABORT_EN adds an abort input that clears
// all stalls.
module pc_stall_timer #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 9,
  parameter int RETRIG_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_CH-1:0]         delayEn,
  input  logic [NUM_CH*CNT_W-1:0]   delayCycles,
`ifdef STALL_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      pcEn,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_r     [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt_s [NUM_CH];
  logic [CNT_W-1:0]  d_s       [NUM_CH];
  logic [CNT_W-1:0]  dec_s     [NUM_CH];
  logic [CNT_W-1:0]  ext_s     [NUM_CH];
  logic [NUM_CH-1:0] den_q_r;
  logic [NUM_CH-1:0] edge_s;
  logic [NUM_CH-1:0] done_r;
  logic [NUM_CH-1:0] done_nxt_s;
  logic              abort_s;

  // Larger of two counts; used when extending a running stall.
  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

`ifdef STALL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // The edge register resets to all-ones so a line held high through reset
  // release is not seen as a new request.
  assign edge_s = delayEn & ~den_q_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign d_s[g]   = delayCycles[g*CNT_W +: CNT_W];
    assign dec_s[g] = cnt_r[g] - CNT_ONE;
    assign ext_s[g] = max_cnt(dec_s[g], d_s[g]);
    assign busy[g]  = (cnt_r[g] != CNT_ZERO);
  end

  assign pcEn = ~|busy;
  assign done = done_r;

  // Per-channel next count and done pulse: load, count down, retrigger, abort.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt_s[i]  = cnt_r[i];
      done_nxt_s[i] = 1'b0;
      if (abort_s) begin
        cnt_nxt_s[i]  = CNT_ZERO;
        done_nxt_s[i] = 1'b0;
      end else if (cnt_r[i] == CNT_ZERO) begin
        if (edge_s[i]) begin
          // A zero-length request completes immediately with a done pulse.
          cnt_nxt_s[i]  = d_s[i];
          done_nxt_s[i] = (d_s[i] == CNT_ZERO);
        end else begin
          cnt_nxt_s[i]  = CNT_ZERO;
          done_nxt_s[i] = 1'b0;
        end
      end else if (edge_s[i] && (RETRIG_MODE == 1)) begin
        cnt_nxt_s[i]  = d_s[i];
        done_nxt_s[i] = (d_s[i] == CNT_ZERO);
      end else if (edge_s[i] && (RETRIG_MODE == 2)) begin
        cnt_nxt_s[i]  = ext_s[i];
        done_nxt_s[i] = (ext_s[i] == CNT_ZERO);
      end else begin
        // Plain countdown; in mode 0 a retrigger edge lands here and is dropped.
        cnt_nxt_s[i]  = dec_s[i];
        done_nxt_s[i] = (dec_s[i] == CNT_ZERO);
      end
    end
  end

  // Counter, done and edge-history registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      done_r  <= {NUM_CH{1'b0}};
      den_q_r <= {NUM_CH{1'b1}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      done_r  <= done_nxt_s;
      den_q_r <= delayEn;
    end
  end

endmodule

// File: tb/tb_pc_stall_timer.sv
// Bench for pc_stall_timer: three instances (retrigger modes 0/1/2) share
// the same stimulus; expected pcEn/busy/done per cycle are queued when
// stimulus is driven and compared after the clock edge.
module tb_pc_stall_timer;

  typedef struct packed {
    logic       pcen;
    logic [1:0] busy;
    logic [1:0] done;
  } obs_t;
  typedef obs_t [2:0] trio_t;

  logic        clk;
  logic        rstn;
  logic [1:0]  den;
  logic [17:0] dcyc;
`ifdef STALL_ABORT_EN
  logic        abort;
`endif
  logic        pcen_s [3];
  logic [1:0]  busy_s [3];
  logic [1:0]  done_s [3];

  trio_t sb_q [$];
  int    errors;
  int    checks;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pc_stall_timer #(.NUM_CH(2), .CNT_W(9), .RETRIG_MODE(g)) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .delayEn     (den),
      .delayCycles (dcyc),
`ifdef STALL_ABORT_EN
      .abort       (abort),
`endif
      .pcEn        (pcen_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic p, input logic [1:0] b, input logic [1:0] d);
    obs_t o;
    o.pcen = p;
    o.busy = b;
    o.done = d;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    trio_t ex;
    rstn = 1'b0;
    den  = 2'b00;
    dcyc = 18'd0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      ex = {mk(1'b1, 2'b00, 2'b00), mk(1'b1, 2'b00, 2'b00), mk(1'b1, 2'b00, 2'b00)};
      sb_q.push_back(ex);
      rstn = (k == 1);
      tick();
      ex = sb_q.pop_front();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if ({pcen_s[m], busy_s[m], done_s[m]} !== ex[m]) begin
          errors++;
          $display("FAIL reset k=%0d mode=%0d got=%b want=%b", k, m,
                   {pcen_s[m], busy_s[m], done_s[m]}, ex[m]);
        end
      end
    end
  endtask

  // Lone stall of length d on channel ch; delay input changed mid-stall.
  task automatic test_stall(input int ch, input int d);
    trio_t ex;
    obs_t  e;
    for (int j = 0; j <= d + 1; j++) begin
      e = mk(j >= d, (j < d) ? (2'b01 << ch) : 2'b00, (j == d) ? (2'b01 << ch) : 2'b00);
      sb_q.push_back({e, e, e});
      if (j == 0) begin
        dcyc[ch*9 +: 9] = 9'(d);
        den[ch] = 1'b1;
      end
      if (j == 2) dcyc[ch*9 +: 9] = 9'd3;
      tick();
      ex = sb_q.pop_front();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if ({pcen_s[m], busy_s[m], done_s[m]} !== ex[m]) begin
          errors++;
          $display("FAIL stall ch=%0d d=%0d j=%0d mode=%0d got=%b want=%b", ch, d, j, m,
                   {pcen_s[m], busy_s[m], done_s[m]}, ex[m]);
        end
      end
    end
    den[ch] = 1'b0;
    tick();
  endtask

  // ch0 D=10 at j=0, ch1 D=4 at j=3.
  task automatic test_overlap();
    trio_t ex;
    obs_t  e;
    logic  b0, b1;
    for (int j = 0; j <= 11; j++) begin
      b0 = (j < 10);
      b1 = (j >= 3) && (j < 7);
      e  = mk(!(b0 || b1), {b1, b0}, {(j == 7), (j == 10)});
      sb_q.push_back({e, e, e});
      if (j == 0) begin
        dcyc[8:0] = 9'd10;
        den[0] = 1'b1;
      end
      if (j == 3) begin
        dcyc[17:9] = 9'd4;
        den[1] = 1'b1;
      end
      tick();
      ex = sb_q.pop_front();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if ({pcen_s[m], busy_s[m], done_s[m]} !== ex[m]) begin
          errors++;
          $display("FAIL overlap j=%0d mode=%0d got=%b want=%b", j, m,
                   {pcen_s[m], busy_s[m], done_s[m]}, ex[m]);
        end
      end
    end
    den = 2'b00;
    tick();
  endtask

  // ch0 started with d0 at j=0, retriggered with r at posedge tr
  // (count before that edge is d0-tr+1).
  task automatic test_retrig(input int d0, input int tr, input int r);
    trio_t ex;
    int    ends [3];
    int    last;
    ends[0] = d0;
    ends[1] = tr + r;
    ends[2] = tr + (((d0 - tr) > r) ? (d0 - tr) : r);
    last = ends[0];
    for (int m = 1; m < 3; m++) if (ends[m] > last) last = ends[m];
    for (int j = 0; j <= last + 1; j++) begin
      for (int m = 0; m < 3; m++) begin
        ex[m] = mk(j >= ends[m], {1'b0, (j < ends[m])}, {1'b0, (j == ends[m])});
      end
      sb_q.push_back(ex);
      if (j == 0) begin
        dcyc[8:0] = 9'(d0);
        den[0] = 1'b1;
      end
      if (j == 1) den[0] = 1'b0;
      if (j == tr) begin
        dcyc[8:0] = 9'(r);
        den[0] = 1'b1;
      end
      tick();
      ex = sb_q.pop_front();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if ({pcen_s[m], busy_s[m], done_s[m]} !== ex[m]) begin
          errors++;
          $display("FAIL retrig d0=%0d tr=%0d r=%0d j=%0d mode=%0d got=%b want=%b",
                   d0, tr, r, j, m, {pcen_s[m], busy_s[m], done_s[m]}, ex[m]);
        end
      end
    end
    den = 2'b00;
    tick();
  endtask

  // Reset at count 50 with delayEn held high through release.
  task automatic test_reset_mid();
    trio_t ex;
    obs_t  e;
    for (int j = 0; j <= 20; j++) begin
      if (j <= 10) e = mk(1'b0, 2'b01, 2'b00);
      else         e = mk(1'b1, 2'b00, 2'b00);
      sb_q.push_back({e, e, e});
      if (j == 0) begin
        dcyc[8:0] = 9'd60;
        den[0] = 1'b1;
      end
      rstn = (j != 11);
      tick();
      ex = sb_q.pop_front();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if ({pcen_s[m], busy_s[m], done_s[m]} !== ex[m]) begin
          errors++;
          $display("FAIL reset_mid j=%0d mode=%0d got=%b want=%b", j, m,
                   {pcen_s[m], busy_s[m], done_s[m]}, ex[m]);
        end
      end
    end
    den = 2'b00;
    tick();
  endtask

`ifdef STALL_ABORT_EN
  // Abort at count 30 with concurrent edges on both channels.
  task automatic test_abort();
    trio_t ex;
    obs_t  e;
    for (int j = 0; j <= 15; j++) begin
      if (j <= 10) e = mk(1'b0, 2'b01, 2'b00);
      else         e = mk(1'b1, 2'b00, 2'b00);
      sb_q.push_back({e, e, e});
      if (j == 0) begin
        dcyc[8:0] = 9'd40;
        den[0] = 1'b1;
      end
      if (j == 1) den[0] = 1'b0;
      if (j == 11) begin
        dcyc[17:9] = 9'd5;
        den = 2'b11;
      end
      abort = (j == 11);
      tick();
      ex = sb_q.pop_front();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if ({pcen_s[m], busy_s[m], done_s[m]} !== ex[m]) begin
          errors++;
          $display("FAIL abort j=%0d mode=%0d got=%b want=%b", j, m,
                   {pcen_s[m], busy_s[m], done_s[m]}, ex[m]);
        end
      end
    end
    den = 2'b00;
    tick();
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
`ifdef STALL_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_stall(0, 256);
    test_stall(1, 0);
    test_stall(1, 511);
    test_stall(0, 1);
    test_overlap();
    test_retrig(8, 4, 20);
    test_retrig(8, 4, 2);
    test_retrig(8, 4, 0);
    test_retrig(4, 4, 3);
    test_retrig(4, 4, 0);
    test_reset_mid();
`ifdef STALL_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
